// File: rtl/riscv_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and access owner.
package riscv_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = requesters + memory.
interface riscv_mem_arbiter_if #(
  parameter int unsigned Bits    = 64,
  parameter int unsigned N       = 32,
  parameter int unsigned MemSize = 16
);
  localparam int unsigned AW = $clog2(MemSize);

  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [N-1:0]    if_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [Bits-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [Bits-1:0] d_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [Bits-1:0] mem_wdata;
  logic [Bits-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and load/store onto one fixed-latency memory; data wins unless fetch has
// waited MAX_STREAK consecutive data grants.
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int unsigned Bits       = 64,
  parameter int unsigned N          = 32,
  parameter int unsigned MemSize    = 16,
  parameter int unsigned LAT        = 2,
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic                clk,
  input  logic                rst,
  riscv_mem_arbiter_if.slave  bus
);

  localparam int unsigned AW = $clog2(MemSize);
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

  arb_state_t      r_state, w_state_nxt;
  owner_t          r_owner;
  logic [AW-1:0]   r_addr;
  logic            r_we;
  logic [Bits-1:0] r_wdata;
  logic [Bits-1:0] r_d_rdata;
  logic [N-1:0]    r_if_rdata;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_streak;

  logic w_arb, w_pick_if, w_if_gnt, w_d_gnt, w_gnt, w_last, w_busy;

  always_comb begin
    // RESP doubles as an arbitration slot so back-to-back accesses lose no cycle
    w_arb       = !rst && (r_state == IDLE || r_state == RESP);
    w_pick_if   = bus.if_req && (!bus.d_req || r_streak == SW'(MAX_STREAK));
    w_if_gnt    = w_arb && w_pick_if;
    w_d_gnt     = w_arb && bus.d_req && !w_pick_if;
    w_gnt       = w_if_gnt || w_d_gnt;
    w_busy      = (r_state == BUSY);
    w_last      = w_busy && (r_cnt == CW'(LAT - 1));
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, RESP: w_state_nxt = w_gnt ? BUSY : IDLE;
      BUSY:       if (w_last) w_state_nxt = RESP;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_d_rdata  <= '0;
      r_if_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_owner <= w_d_gnt ? OWN_D : OWN_IF;
        r_addr  <= w_d_gnt ? bus.d_addr : bus.if_addr;
        r_we    <= w_d_gnt && bus.d_we;
        r_wdata <= w_d_gnt ? bus.d_wdata : '0;
        r_cnt   <= '0;
      end else if (w_busy && !w_last) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_d_gnt && bus.if_req) begin
        if (r_streak != SW'(MAX_STREAK)) r_streak <= r_streak + SW'(1);
      end else if (w_gnt) begin
        r_streak <= '0;
      end
      // Each requester keeps its own read-data register so the other bus holds its value
      if (w_last) begin
        if (r_owner == OWN_D) r_d_rdata <= r_we ? '0 : bus.mem_rdata;
        else                  r_if_rdata <= bus.mem_rdata[N-1:0];
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.if_rvalid = !rst && (r_state == RESP) && (r_owner == OWN_IF);
  assign bus.d_rvalid  = !rst && (r_state == RESP) && (r_owner == OWN_D);
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = w_busy;
  assign bus.mem_we    = w_busy && r_we;
  assign bus.mem_addr  = w_busy ? r_addr : '0;
  assign bus.mem_wdata = w_busy ? r_wdata : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a behavioural single-port memory.
module tb_riscv_mem_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  riscv_mem_arbiter_if #(.Bits(64), .N(32), .MemSize(16)) bus ();

  riscv_mem_arbiter #(
    .Bits(64), .N(32), .MemSize(16), .LAT(2), .MAX_STREAK(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mem [16];
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [63:0] pre_data;

  assign bus.mem_rdata = bus.mem_en ? mem[bus.mem_addr] : 64'h0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we)              mem[pre_addr] <= pre_data;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [63:0] d);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_gnt1: got %b want 00", {bus.if_gnt, bus.d_gnt});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 000000",
               {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.mem_we});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr %h wdata %h ird %h drd %h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_first_gnt: got %b want 01", {bus.if_gnt, bus.d_gnt});
    end
    step();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_fetch();
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 4'd4;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
      n_err++;
      $display("FAIL fetch_gnt: got %b want 10", {bus.if_gnt, bus.d_gnt});
    end
    step();
    bus.if_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.if_rvalid} !== {1'b1, 1'b0, 4'd4, 1'b0}) begin
        n_err++;
        $display("FAIL fetch_mem_c%0d: got en %b we %b addr %h rv %b want 1 0 4 0",
                 c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.if_rvalid);
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.if_rdata} !== {3'b100, 32'h00500093}) begin
      n_err++;
      $display("FAIL fetch_resp: got rv %b drv %b en %b data %h want 1 0 0 00500093",
               bus.if_rvalid, bus.d_rvalid, bus.mem_en, bus.if_rdata);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b0, 32'h00500093}) begin
      n_err++;
      $display("FAIL fetch_hold: got rv %b data %h want 0 00500093", bus.if_rvalid, bus.if_rdata);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 4'd7;
    bus.d_wdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    n_cmp++;
    if (bus.d_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL store_gnt: got %b want 1", bus.d_gnt);
    end
    step();
    bus.d_req   = 1'b0;
    bus.d_wdata = 64'h0123_4567_89AB_CDEF;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
          !== {2'b11, 4'd7, 64'hDEADBEEF_CAFEF00D}) begin
        n_err++;
        $display("FAIL store_mem_c%0d: got en %b we %b addr %h wd %h want 1 1 7 deadbeefcafef00d",
                 c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      step();
    end
    bus.d_req = 1'b1;
    bus.d_we  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_rdata, bus.d_gnt, bus.mem_we} !== {1'b1, 64'h0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL store_resp: got rv %b data %h gnt %b we %b want 1 0 1 0",
               bus.d_rvalid, bus.d_rdata, bus.d_gnt, bus.mem_we);
    end
    n_cmp++;
    if (mem[7] !== 64'hDEADBEEF_CAFEF00D) begin
      n_err++;
      $display("FAIL store_mem7: got %h want deadbeefcafef00d", mem[7]);
    end
    step();
    bus.d_req = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 64'hDEADBEEF_CAFEF00D}) begin
      n_err++;
      $display("FAIL load_resp: got rv %b data %h want 1 deadbeefcafef00d",
               bus.d_rvalid, bus.d_rdata);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 4'd4;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 4'd7;
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
      n_err++;
      $display("FAIL coll_gnt_t0: got %b want 01", {bus.if_gnt, bus.d_gnt});
    end
    step();
    bus.d_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.if_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL coll_early_if_gnt_c%0d: got %b want 0", c, bus.if_gnt);
      end
      step();
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.if_gnt, bus.d_rvalid, bus.d_rdata} !== {2'b11, 64'hDEADBEEF_CAFEF00D}) begin
      n_err++;
      $display("FAIL coll_t3: got ifgnt %b drv %b data %h want 1 1 deadbeefcafef00d",
               bus.if_gnt, bus.d_rvalid, bus.d_rdata);
    end
    step();
    bus.if_req = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h00500093}) begin
      n_err++;
      $display("FAIL coll_t6: got rv %b data %h want 1 00500093", bus.if_rvalid, bus.if_rdata);
    end
  endtask

  task automatic test_starvation();
    logic kind [8];
    int   cyc [8];
    int   n_g;
    int   both;
    n_g  = 0;
    both = 0;
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 4'd4;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 4'd7;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.d_gnt && bus.if_gnt) both++;
      if (bus.d_gnt || bus.if_gnt) begin
        if (n_g < 8) begin
          kind[n_g] = bus.if_gnt;
          cyc[n_g]  = c;
        end
        n_g++;
      end
      step();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    n_cmp++;
    if (n_g !== 8 || both !== 0) begin
      n_err++;
      $display("FAIL starve_count: got %0d grants %0d dual want 8 grants 0 dual", n_g, both);
    end
    for (int i = 0; i < 8 && i < n_g; i++) begin
      n_cmp++;
      if (kind[i] !== (i % 4 == 3) || cyc[i] !== 3 * i) begin
        n_err++;
        $display("FAIL starve_g%0d: got if=%b at %0d want if=%b at %0d",
                 i, kind[i], cyc[i], (i % 4 == 3), 3 * i);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 4'd7;
    @(negedge clk);
    n_cmp++;
    if (bus.d_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL mid_gnt: got %b want 1", bus.d_gnt);
    end
    step();
    bus.d_req = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.d_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rv_t2: got %b want 0", bus.d_rvalid);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.if_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.d_rdata,
         bus.if_rdata} !== '0) begin
      n_err++;
      $display("FAIL mid_t3: got drv %b irv %b en %b we %b addr %h drd %h ird %h want all 0",
               bus.d_rvalid, bus.if_rvalid, bus.mem_en, bus.mem_we, bus.mem_addr, bus.d_rdata,
               bus.if_rdata);
    end
    step();
    bus.d_req = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.d_gnt !== 1'b1) begin
      n_err++;
      $display("FAIL mid_regnt: got %b want 1", bus.d_gnt);
    end
    step();
    bus.d_req = 1'b0;
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 64'hDEADBEEF_CAFEF00D}) begin
      n_err++;
      $display("FAIL mid_reload: got rv %b data %h want 1 deadbeefcafef00d",
               bus.d_rvalid, bus.d_rdata);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    preload(4'd4, 64'h11223344_00500093);
    test_fetch();
    test_store_load();
    test_collision();
    test_starvation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares one single-ported unified memory between instruction fetch (read-only, N-bit) and the load/store unit (read/write, Bits-wide) of the Procesador_RISC_V core. The memory has a fixed access latency; the arbiter sequences each access and returns completion/read data to the winning requester. Data accesses have priority, and a streak counter guarantees fetch progress.

Parameters:
Bits, 64, memory word / data-port width
N, 32, instruction width; fetch data is mem word bits [N-1:0]
MemSize, 16, words in memory; power of 2
AW, $clog2(MemSize), address width (derived, localparam)
LAT, 2, memory read/write latency in cycles, >= 1
MAX_STREAK, 3, consecutive data grants allowed while fetch waits

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, held until if_gnt
if_addr  in  AW  fetch word address
if_gnt  out  1  fetch request accepted (1-cycle pulse)
if_rvalid  out  1  fetch data valid (1-cycle pulse)
if_rdata  out  N  instruction
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data word address
d_wdata  in  Bits  store data
d_gnt  out  1  data request accepted (1-cycle pulse)
d_rvalid  out  1  load data valid / store complete (1-cycle pulse)
d_rdata  out  Bits  load data; 0 for stores
mem_en  out  1  memory access active
mem_we  out  1  memory write
mem_addr  out  AW  memory address
mem_wdata  out  Bits  memory write data
mem_rdata  in  Bits  memory read data, valid on last access cycle

Behaviour:
- Reset (clk edge with rst=1): state IDLE, streak=0, all outputs 0 including rdata buses.
- FSM states: IDLE, BUSY, RESP.
- IDLE, cycle T: arbitrate; gnt is combinational from req and state, asserted in T. Pick d unless (if_req and streak==MAX_STREAK); else if. Latch owner, addr, we (0 for fetch), wdata. Go BUSY. No req: stay IDLE.
- BUSY, T+1..T+LAT: mem_en=1; mem_addr/mem_we/mem_wdata from latched regs; cnt counts 0..LAT-1. At cnt==LAT-1, register mem_rdata (0 if write), go RESP.
- RESP, T+LAT+1: owner's rvalid=1 with registered data. Same cycle acts as IDLE, so arbitration and a new gnt may occur. Back-to-back throughput is one access per LAT+1 cycles.
- Streak update at each grant:
  - data grant with if_req=1: streak+1, saturating at MAX_STREAK.
  - fetch grant, or data grant with if_req=0: streak=0.
- mem_* outputs are 0 outside BUSY. rdata buses hold their last value when rvalid=0. Only after reset are they 0.
- Req deassertion before gnt is legal; the request is dropped. Inputs after gnt are ignored until the next grant.
- Reset in BUSY/RESP aborts the access: no rvalid, the write stops (partial mem_we permitted), IDLE next cycle.

Decomposition:
- Package riscv_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - owner_t enum {OWN_IF, OWN_D}
- Streak counter is small and stays inline; no sub-module.

Test Plan:
- Reset: rst=1 for 2 edges with both reqs high -> all outputs 0, no gnt while rst=1; first gnt one cycle after rst drops.
- Single fetch: mem[4]=0x11223344_00500093, if_req addr 4 at T -> if_gnt at T; mem_en and addr=4 at T+1 and T+2; if_rvalid at T+3 with if_rdata=0x00500093.
- Store then load: d_we=1, addr 7, wdata 0xDEADBEEF_CAFEF00D -> mem_we=1 for 2 cycles, d_rvalid at T+3 with d_rdata=0. Load addr 7 granted at T+3 -> d_rvalid at T+6 with 0xDEADBEEF_CAFEF00D.
- Collision: if_req and d_req both rise at T -> d_gnt at T, if_gnt at T+3, if_rvalid at T+6.
- Starvation: both reqs held continuously -> grant order d,d,d,if,d,d,d,if; grants every 3 cycles.
- Reset mid-access: rst=1 at T+2 of a load -> no d_rvalid; IDLE at T+3; outputs 0; a fresh request is granted normally.
